digital_scan_driver: RTL

- Time-multiplexing driver for the 4-digit seven-segment display on the peripheral bus.
- It consumes the value the CPU stores to the digital-tube register, and scans the four digits one at a time.
- It produces the 12-bit drive word {anodes[3:0], segments[7:0]} that feeds the board pins.
- A new value is applied only at frame boundaries, so the display never shows a mix of old and new digits.

---
 rtl/digital_scan_driver_if.sv | 26 ++
 rtl/digital_scan_driver.sv | 138 +++++++++++++
 2 files changed

// File: rtl/digital_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : digital_scan_driver_if
// Brief    : CPU-side register strobe and display drive bundle for the
//            seven-segment scan driver.
// Revision : 1.0 - initial release
// ============================================================================
interface digital_scan_driver_if;
    logic        i_load;
    logic [15:0] i_value;
    logic [3:0]  i_dp;
    logic [11:0] o_digital;
    logic        o_pending;
    logic        o_frame;

    modport master (
        output i_load, i_value, i_dp,
        input  o_digital, o_pending, o_frame
    );

    modport slave (
        input  i_load, i_value, i_dp,
        output o_digital, o_pending, o_frame
    );
endinterface
`default_nettype wire

// File: rtl/digital_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : digital_scan_driver
// Brief    : 4-digit seven-segment time-multiplexing driver with frame-aligned
//            value update. Optional macro: DIGITAL_LEADING_ZERO_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module digital_scan_driver #(
    parameter int SCAN_DIV = 100000
) (
    input  wire logic               clk,
    input  wire logic               reset,
    digital_scan_driver_if.slave    bus_if
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      act_val_q, act_val_d;
    logic [3:0]       act_dp_q, act_dp_d;
    logic [15:0]      pend_val_q, pend_val_d;
    logic [3:0]       pend_dp_q, pend_dp_d;
    logic             pend_flag_q, pend_flag_d;
    logic             frame_q, frame_d;
    logic [11:0]      digital_q, digital_d;

    logic             tick;
    logic             frame_bnd;
    logic [3:0]       nib;
    logic [6:0]       seg_lo;
    logic             blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        tick        = (div_q == CNT_W'(SCAN_DIV - 1));
        frame_bnd   = tick && (idx_q == 2'd3);
        div_d       = tick ? '0 : div_q + CNT_W'(1);
        idx_d       = tick ? idx_q + 2'd1 : idx_q;
        frame_d     = frame_bnd;

        act_val_d   = act_val_q;
        act_dp_d    = act_dp_q;
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        pend_flag_d = pend_flag_q;

        // Boundary consumes the pre-edge pending contents; a coincident load
        // then re-arms pending for the following frame.
        if (frame_bnd && pend_flag_q) begin
            act_val_d = pend_val_q;
            act_dp_d  = pend_dp_q;
        end
        if (frame_bnd) begin
            pend_flag_d = 1'b0;
        end
        if (bus_if.i_load) begin
            pend_val_d  = bus_if.i_value;
            pend_dp_d   = bus_if.i_dp;
            pend_flag_d = 1'b1;
        end

        // act_val_d already holds the freshly transferred value, so digit 0
        // on the boundary edge shows the new data without a frame of lag.
        nib    = act_val_d[{idx_d, 2'b00} +: 4];
        seg_lo = seg_decode(nib);
`ifdef DIGITAL_LEADING_ZERO_BLANK_EN
        case (idx_d)
            2'd3:    blank = (act_val_d[15:12] == 4'h0);
            2'd2:    blank = (act_val_d[15:8]  == 8'h00);
            2'd1:    blank = (act_val_d[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        if (blank) begin
            seg_lo = 7'h7F;
        end

        digital_d = digital_q;
        if (tick) begin
            digital_d = {~(4'b0001 << idx_d), ~act_dp_d[idx_d], seg_lo};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q       <= '0;
            idx_q       <= 2'd3;
            act_val_q   <= '0;
            act_dp_q    <= '0;
            pend_val_q  <= '0;
            pend_dp_q   <= '0;
            pend_flag_q <= 1'b0;
            frame_q     <= 1'b0;
            digital_q   <= 12'hFFF;
        end else begin
            div_q       <= div_d;
            idx_q       <= idx_d;
            act_val_q   <= act_val_d;
            act_dp_q    <= act_dp_d;
            pend_val_q  <= pend_val_d;
            pend_dp_q   <= pend_dp_d;
            pend_flag_q <= pend_flag_d;
            frame_q     <= frame_d;
            digital_q   <= digital_d;
        end
    end

    assign bus_if.o_digital = digital_q;
    assign bus_if.o_pending = pend_flag_q;
    assign bus_if.o_frame   = frame_q;

endmodule
`default_nettype wire
